ensemble_vote_combiner: RTL and testbench



---
 rtl/ensemble_pkg.sv | 50 +++++
 rtl/axis_pred_fifo.sv | 67 ++++++
 rtl/ensemble_vote_combiner.sv | 170 +++++++++++++++++
 tb/tb_ensemble_vote_combiner.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ensemble_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ensemble_pkg
// Description : Shared constants, FSM state type and majority-vote helper for
//               the ensemble vote combiner.
// Revision    : 1.0 - initial release
// ============================================================================
package ensemble_pkg;

  localparam int VOTE_LSB        = 16;
  localparam int MISMATCH_BIT    = 24;
  // Labels are widened to this width before voting; CLASS_WIDTH must not exceed it.
  localparam int MAX_CLASS_WIDTH = 16;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  typedef struct packed {
    logic [MAX_CLASS_WIDTH-1:0] label;
    logic [1:0]                 votes;
  } vote_t;

  function automatic vote_t majority_vote(
    input logic [MAX_CLASS_WIDTH-1:0] l0,
    input logic [MAX_CLASS_WIDTH-1:0] l1,
    input logic [MAX_CLASS_WIDTH-1:0] l2,
    input int                         tie_priority
  );
    vote_t r;
    if ((l0 == l1) || (l0 == l2)) begin
      r.label = l0;
      r.votes = ((l0 == l1) && (l0 == l2)) ? 2'd3 : 2'd2;
    end else if (l1 == l2) begin
      r.label = l1;
      r.votes = 2'd2;
    end else begin
      r.votes = 2'd1;
      case (tie_priority)
        1:       r.label = l1;
        2:       r.label = l2;
        default: r.label = l0;
      endcase
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_pred_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_pred_fifo
// Description : Synchronous FIFO with wrap-bit pointers and registered
//               full/empty flags; head word is visible on rd_data.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pred_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int c_addr_w = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_addr_w:0] r_wr_ptr;
  logic [c_addr_w:0] r_rd_ptr;
  logic [c_addr_w:0] w_wr_ptr_nxt;
  logic [c_addr_w:0] w_rd_ptr_nxt;
  logic              r_full;
  logic              r_empty;
  logic              w_do_rd;
  logic              w_do_wr;

  // A write into a full FIFO is legal only when a pop frees the slot that cycle.
  assign w_do_rd = rd_en & ~r_empty;
  assign w_do_wr = wr_en & (~r_full | w_do_rd);

  assign w_wr_ptr_nxt = r_wr_ptr + {{c_addr_w{1'b0}}, w_do_wr};
  assign w_rd_ptr_nxt = r_rd_ptr + {{c_addr_w{1'b0}}, w_do_rd};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_full   <= (w_wr_ptr_nxt[c_addr_w] != w_rd_ptr_nxt[c_addr_w]) &&
                  (w_wr_ptr_nxt[c_addr_w-1:0] == w_rd_ptr_nxt[c_addr_w-1:0]);
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[c_addr_w-1:0]] <= wr_data;
    end
  end

  assign rd_data = r_mem[r_rd_ptr[c_addr_w-1:0]];
  assign full    = r_full;
  assign empty   = r_empty;

endmodule
`default_nettype wire

// File: rtl/ensemble_vote_combiner.sv
`default_nettype none
// ============================================================================
// Module      : ensemble_vote_combiner
// Description : Buffers three classifier prediction streams, aligns one word
//               from each, majority-votes the label and emits a decision.
// Revision    : 1.0 - initial release
// ============================================================================
module ensemble_vote_combiner
  import ensemble_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = 4,
  parameter int CLASS_WIDTH  = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIE_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
  input  logic                  s_axis_tvalid_0,
  output logic                  s_axis_tready_0,
  input  logic                  s_axis_tlast_0,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           sample_count,
  output logic [31:0]           disagree_count
);

  logic [DATA_WIDTH:0]   w_wr_data [3];
  logic [DATA_WIDTH:0]   w_rd_data [3];
  logic [2:0]            w_in_valid;
  logic [2:0]            w_wr_en;
  logic [2:0]            w_full;
  logic [2:0]            w_empty;
  logic [2:0]            w_tready;
  logic [2:0]            w_lasts;
  logic                  w_all_avail;
  logic                  w_pop;
  vote_t                 w_vote;
  logic [DATA_WIDTH-1:0] w_dec;
  logic                  w_unused;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic [KEEP_WIDTH-1:0] r_keep;
  logic                  r_valid;
  logic                  r_last;
  logic [31:0]           r_sample_count;
  logic [31:0]           r_disagree_count;

  assign w_wr_data[0] = {s_axis_tlast_0, s_axis_tdata_0};
  assign w_wr_data[1] = {s_axis_tlast_1, s_axis_tdata_1};
  assign w_wr_data[2] = {s_axis_tlast_2, s_axis_tdata_2};
  assign w_in_valid   = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};

  // Ready comes from registered full only and is forced low while in reset.
  assign w_tready = ~w_full & {3{~rst}};
  assign w_wr_en  = w_in_valid & w_tready;

  assign s_axis_tready_0 = w_tready[0];
  assign s_axis_tready_1 = w_tready[1];
  assign s_axis_tready_2 = w_tready[2];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_fifo
      axis_pred_fifo #(
        .WIDTH(DATA_WIDTH + 1),
        .DEPTH(FIFO_DEPTH)
      ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (w_wr_en[g]),
        .wr_data(w_wr_data[g]),
        .rd_en  (w_pop),
        .rd_data(w_rd_data[g]),
        .full   (w_full[g]),
        .empty  (w_empty[g])
      );
    end
  endgenerate

  assign w_all_avail = ~|w_empty;
  assign w_pop       = w_all_avail & ((r_state == COLLECT) | m_axis_tready);
  assign w_lasts     = {w_rd_data[2][DATA_WIDTH], w_rd_data[1][DATA_WIDTH],
                        w_rd_data[0][DATA_WIDTH]};

  assign w_vote = majority_vote(MAX_CLASS_WIDTH'(w_rd_data[0][CLASS_WIDTH-1:0]),
                                MAX_CLASS_WIDTH'(w_rd_data[1][CLASS_WIDTH-1:0]),
                                MAX_CLASS_WIDTH'(w_rd_data[2][CLASS_WIDTH-1:0]),
                                TIE_PRIORITY);

  always_comb begin
    w_dec                    = '0;
    w_dec[CLASS_WIDTH-1:0]   = w_vote.label[CLASS_WIDTH-1:0];
    w_dec[VOTE_LSB +: 2]     = w_vote.votes;
    w_dec[MISMATCH_BIT]      = ~((&w_lasts) | ~(|w_lasts));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= COLLECT;
      r_data           <= '0;
      r_keep           <= '0;
      r_valid          <= 1'b0;
      r_last           <= 1'b0;
      r_sample_count   <= '0;
      r_disagree_count <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_all_avail) begin
            r_data  <= w_dec;
            r_last  <= |w_lasts;
            r_keep  <= '1;
            r_valid <= 1'b1;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (m_axis_tready) begin
            r_sample_count <= r_sample_count + 32'd1;
            if (r_data[VOTE_LSB +: 2] != 2'd3) begin
              r_disagree_count <= r_disagree_count + 32'd1;
            end
            // Back-to-back reload keeps one decision per cycle under sustained input.
            if (w_all_avail) begin
              r_data <= w_dec;
              r_last <= |w_lasts;
            end else begin
              r_valid <= 1'b0;
              r_keep  <= '0;
              r_state <= COLLECT;
            end
          end
        end
        default: begin
          r_state <= COLLECT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata   = r_data;
  assign m_axis_tkeep   = r_keep;
  assign m_axis_tvalid  = r_valid;
  assign m_axis_tlast   = r_last;
  assign sample_count   = r_sample_count;
  assign disagree_count = r_disagree_count;

  // tkeep inputs and upper payload bits are intentionally not consumed.
  assign w_unused = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                      w_rd_data[0], w_rd_data[1], w_rd_data[2], w_vote.label};

endmodule
`default_nettype wire

// File: tb/tb_ensemble_vote_combiner.sv
`default_nettype none
// ============================================================================
// Module      : tb_ensemble_vote_combiner
// Description : Scoreboard bench for ensemble_vote_combiner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ensemble_vote_combiner;

  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int CW    = 8;
  localparam int DEPTH = 4;
  localparam int TIE   = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata [3];
  logic [KW-1:0] s_tkeep [3];
  logic [2:0]    s_tvalid;
  logic [2:0]    s_tready;
  logic [2:0]    s_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [31:0]   sample_count;
  logic [31:0]   disagree_count;

  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  logic [DW:0] q2[$];
  exp_t        exp_q[$];
  logic [2:0]  en  = 3'b111;
  logic [2:0]  acc = 3'b000;
  int n_checks = 0;
  int n_pass   = 0;
  int model_samples  = 0;
  int model_disagree = 0;

  always #5 clk = ~clk;

  ensemble_vote_combiner #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_WIDTH(CW),
    .FIFO_DEPTH(DEPTH), .TIE_PRIORITY(TIE)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata_0(s_tdata[0]), .s_axis_tkeep_0(s_tkeep[0]), .s_axis_tvalid_0(s_tvalid[0]),
    .s_axis_tready_0(s_tready[0]), .s_axis_tlast_0(s_tlast[0]),
    .s_axis_tdata_1(s_tdata[1]), .s_axis_tkeep_1(s_tkeep[1]), .s_axis_tvalid_1(s_tvalid[1]),
    .s_axis_tready_1(s_tready[1]), .s_axis_tlast_1(s_tlast[1]),
    .s_axis_tdata_2(s_tdata[2]), .s_axis_tkeep_2(s_tkeep[2]), .s_axis_tvalid_2(s_tvalid[2]),
    .s_axis_tready_2(s_tready[2]), .s_axis_tlast_2(s_tlast[2]),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .sample_count(sample_count), .disagree_count(disagree_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                 input logic [CW-1:0] c, input logic [2:0] l);
    exp_t e;
    logic [CW-1:0] lab;
    logic [1:0] v;
    if (a == b && b == c)      begin lab = a; v = 2'd3; end
    else if (a == b || a == c) begin lab = a; v = 2'd2; end
    else if (b == c)           begin lab = b; v = 2'd2; end
    else begin
      v   = 2'd1;
      lab = (TIE == 0) ? a : ((TIE == 1) ? b : c);
    end
    e.data          = '0;
    e.data[CW-1:0]  = lab;
    e.data[17:16]   = v;
    e.data[24]      = !(l == 3'b000 || l == 3'b111);
    e.last          = |l;
    return e;
  endfunction

  task automatic enq(input logic [CW-1:0] a, input logic [CW-1:0] b,
                     input logic [CW-1:0] c, input logic [2:0] l);
    logic [DW-1:0] w;
    w = $urandom; w[CW-1:0] = a; q0.push_back({l[0], w});
    w = $urandom; w[CW-1:0] = b; q1.push_back({l[1], w});
    w = $urandom; w[CW-1:0] = c; q2.push_back({l[2], w});
    exp_q.push_back(model(a, b, c, l));
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", tag}, exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Input drivers: a word leaves its queue once the handshake seen at negedge completes.
  initial begin
    s_tvalid = '0;
    s_tlast  = '0;
    for (int s = 0; s < 3; s++) begin
      s_tdata[s] = '0;
      s_tkeep[s] = '1;
    end
    forever begin
      @(posedge clk);
      #1;
      if (acc[0]) q0.delete(0);
      if (acc[1]) q1.delete(0);
      if (acc[2]) q2.delete(0);
      s_tvalid[0] = en[0] && (q0.size() != 0);
      s_tvalid[1] = en[1] && (q1.size() != 0);
      s_tvalid[2] = en[2] && (q2.size() != 0);
      if (q0.size() != 0) {s_tlast[0], s_tdata[0]} = q0[0];
      if (q1.size() != 0) {s_tlast[1], s_tdata[1]} = q1[0];
      if (q2.size() != 0) {s_tlast[2], s_tdata[2]} = q2[0];
    end
  end

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    acc = s_tvalid & s_tready;
    if (!rst) begin
      check("sample_count", sample_count, model_samples);
      check("disagree_count", disagree_count, model_disagree);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("output_without_pending_sample", m_tvalid & m_tready, 0);
        end else begin
          e = exp_q.pop_front();
          check("m_tdata", m_tdata, e.data);
          check("m_tlast", m_tlast, e.last);
          check("m_tkeep", m_tkeep, 4'hF);
          model_samples++;
          if (e.data[17:16] != 2'd3) model_disagree++;
        end
      end
    end
  end

  initial begin
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("tready_during_reset", s_tready, 3'b000);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tkeep", m_tkeep, 0);
    check("rst_tready", s_tready, 3'b111);

    // Aligned 5,5,5: FIFO write then output register.
    @(posedge clk); #2 m_tready = 1'b1;
    enq(8'd5, 8'd5, 8'd5, 3'b000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("lat_not_yet_valid", m_tvalid, 0);
    @(negedge clk);
    check("lat_valid", m_tvalid, 1);
    check("lat_tdata", m_tdata, 32'h0003_0005);
    check("lat_tlast", m_tlast, 0);
    wait_drain("555");
    check("cnt_after_555", sample_count, 1);
    check("dis_after_555", disagree_count, 0);

    // Pair majority and three-way tie.
    @(posedge clk); #2;
    enq(8'd3, 8'd7, 8'd7, 3'b000);
    enq(8'd1, 8'd2, 8'd3, 3'b000);
    wait_drain("pair_tie");
    check("dis_after_tie", disagree_count, 2);

    // Stream 2 held back: streams 0/1 fill their FIFOs and stall.
    @(posedge clk); #2 en = 3'b011;
    for (int i = 0; i < 6; i++)
      enq(CW'($urandom_range(0, 3)), CW'($urandom_range(0, 3)), CW'($urandom_range(0, 3)), 3'b000);
    repeat (12) @(negedge clk);
    check("skew_tready", s_tready, 3'b100);
    check("skew_no_output", m_tvalid, 0);
    @(posedge clk); #2 en = 3'b111;
    wait_drain("skew");
    check("cnt_after_skew", sample_count, 9);

    // Downstream backpressure: output holds, then queued decisions drain back-to-back.
    @(posedge clk); #2 m_tready = 1'b0;
    for (int i = 0; i < 5; i++) enq(CW'(i + 10), CW'(i + 10), CW'(i + 20), 3'b000);
    repeat (12) @(negedge clk);
    check("bp_fifos_full", s_tready, 3'b000);
    for (int i = 0; i < 5; i++) begin
      check("bp_tvalid_held", m_tvalid, 1);
      check("bp_tdata_held", m_tdata, exp_q[0].data);
      @(negedge clk);
    end
    @(posedge clk); #2 m_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_consecutive", m_tvalid, 1);
    end
    @(negedge clk);
    check("bp_back_to_collect", m_tvalid, 0);

    // tlast disagreement.
    @(posedge clk); #2;
    enq(8'd4, 8'd4, 8'd4, 3'b011);
    enq(8'd9, 8'd9, 8'd9, 3'b111);
    wait_drain("tlast");

    // Mid-flight reset discards everything buffered.
    @(posedge clk); #2 m_tready = 1'b0;
    for (int i = 0; i < 3; i++) enq(8'd40, 8'd41, 8'd42, 3'b000);
    repeat (10) @(posedge clk);
    #2;
    enq(8'd50, 8'd50, 8'd50, 3'b000);
    enq(8'd51, 8'd51, 8'd51, 3'b000);
    @(posedge clk); #2;
    rst = 1'b1;
    q0.delete(); q1.delete(); q2.delete(); exp_q.delete();
    model_samples  = 0;
    model_disagree = 0;
    @(negedge clk);
    check("tready_in_mid_reset", s_tready, 3'b000);
    @(posedge clk); #2;
    rst      = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    check("post_rst_tvalid", m_tvalid, 0);
    check("post_rst_tready", s_tready, 3'b111);
    check("post_rst_samples", sample_count, 0);
    check("post_rst_disagree", disagree_count, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_idle", m_tvalid, 0);
    end
    @(posedge clk); #2;
    enq(8'd2, 8'd2, 8'd6, 3'b000);
    wait_drain("post_rst");
    check("cnt_after_rst", sample_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
